// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: the active-low abcdefg pattern table
// (bit6=a .. bit0=g, 0 = lit) used by both the encoder and the capture
// decoder, the decode result struct and the capture FSM state type.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG7_0     = 7'b0000001;
  localparam seg7_t SEG7_1     = 7'b1001111;
  localparam seg7_t SEG7_2     = 7'b0010010;
  localparam seg7_t SEG7_3     = 7'b0000110;
  localparam seg7_t SEG7_4     = 7'b1001100;
  localparam seg7_t SEG7_5     = 7'b0100100;
  localparam seg7_t SEG7_6     = 7'b0100000;
  localparam seg7_t SEG7_7     = 7'b0001111;
  localparam seg7_t SEG7_8     = 7'b0000000;
  localparam seg7_t SEG7_9     = 7'b0001100;
  localparam seg7_t SEG7_A     = 7'b0001000;
  localparam seg7_t SEG7_B     = 7'b1100000;
  localparam seg7_t SEG7_C     = 7'b0110001;
  localparam seg7_t SEG7_D     = 7'b1000010;
  localparam seg7_t SEG7_E     = 7'b0110000;
  localparam seg7_t SEG7_F     = 7'b0111000;
  localparam seg7_t SEG7_BLANK = 7'b1111111;

  // Blank is legal (legal=1, blank=1) but carries no nibble.
  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] nibble;
  } seg7_dec_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2
  } cap_state_t;

  // Forward table used by the hex-to-7-segment encoder.
  function automatic seg7_t seg7_encode(input logic [3:0] nibble);
    seg7_t pat;
    case (nibble)
      4'h0:    pat = SEG7_0;
      4'h1:    pat = SEG7_1;
      4'h2:    pat = SEG7_2;
      4'h3:    pat = SEG7_3;
      4'h4:    pat = SEG7_4;
      4'h5:    pat = SEG7_5;
      4'h6:    pat = SEG7_6;
      4'h7:    pat = SEG7_7;
      4'h8:    pat = SEG7_8;
      4'h9:    pat = SEG7_9;
      4'hA:    pat = SEG7_A;
      4'hB:    pat = SEG7_B;
      4'hC:    pat = SEG7_C;
      4'hD:    pat = SEG7_D;
      4'hE:    pat = SEG7_E;
      4'hF:    pat = SEG7_F;
      default: pat = SEG7_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the seven-segment table: pattern in,
// {legal, blank, nibble} out. Anything not in the table and not blank
// is reported as illegal.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  seg7_t     pattern_i,
  output seg7_dec_t dec_o
);

  // Table lookup; default branch flags the pattern as illegal.
  always_comb begin
    dec_o = '{legal: 1'b0, blank: 1'b0, nibble: 4'h0};
    case (pattern_i)
      SEG7_0:     dec_o = '{legal: 1'b1, blank: 1'b0, nibble: 4'h0};
      SEG7_1:     dec_o = '{legal: 1'b1, blank: 1'b0, nibble: 4'h1};
      SEG7_2:     dec_o = '{legal: 1'b1, blank: 1'b0, nibble: 4'h2};
      SEG7_3:     dec_o = '{legal: 1'b1, blank: 1'b0, nibble: 4'h3};
      SEG7_4:     dec_o = '{legal: 1'b1, blank: 1'b0, nibble: 4'h4};
      SEG7_5:     dec_o = '{legal: 1'b1, blank: 1'b0, nibble: 4'h5};
      SEG7_6:     dec_o = '{legal: 1'b1, blank: 1'b0, nibble: 4'h6};
      SEG7_7:     dec_o = '{legal: 1'b1, blank: 1'b0, nibble: 4'h7};
      SEG7_8:     dec_o = '{legal: 1'b1, blank: 1'b0, nibble: 4'h8};
      SEG7_9:     dec_o = '{legal: 1'b1, blank: 1'b0, nibble: 4'h9};
      SEG7_A:     dec_o = '{legal: 1'b1, blank: 1'b0, nibble: 4'hA};
      SEG7_B:     dec_o = '{legal: 1'b1, blank: 1'b0, nibble: 4'hB};
      SEG7_C:     dec_o = '{legal: 1'b1, blank: 1'b0, nibble: 4'hC};
      SEG7_D:     dec_o = '{legal: 1'b1, blank: 1'b0, nibble: 4'hD};
      SEG7_E:     dec_o = '{legal: 1'b1, blank: 1'b0, nibble: 4'hE};
      SEG7_F:     dec_o = '{legal: 1'b1, blank: 1'b0, nibble: 4'hF};
      SEG7_BLANK: dec_o = '{legal: 1'b1, blank: 1'b1, nibble: 4'h0};
      default:    dec_o = '{legal: 1'b0, blank: 1'b0, nibble: 4'h0};
    endcase
  end

endmodule

// File: rtl/seven_segment_decoder_capture.sv
// Seven-segment bus capture: synchronizes a multiplexed active-low
// abcdefg bus with one-hot digit selects, waits for STABLE_CYCLES
// identical samples, then decodes the pattern into a per-digit
// value/valid register file. A steady bus is captured once.
// Optional macro SEGDEC_ERRCNT_EN adds the saturating err_cnt_o counter.
module seven_segment_decoder_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_i,
  input  logic [NUM_DIGITS-1:0]   dig_sel_i,
  input  logic                    clear_i,
  output logic [4*NUM_DIGITS-1:0] value_o,
  output logic [NUM_DIGITS-1:0]   valid_o,
  output logic                    upd_o,
  output logic [2:0]              upd_idx_o,
  output logic                    err_o
`ifdef SEGDEC_ERRCNT_EN
  ,
  output logic [7:0]              err_cnt_o
`endif
);

  localparam int         BUS_W    = 7 + NUM_DIGITS;
  localparam logic [7:0] STABLE_W = STABLE_CYCLES[7:0];

  // Synchronizer pair plus one history register for change detection.
  logic [BUS_W-1:0] sync1_q;
  logic [BUS_W-1:0] s2_q;
  logic [BUS_W-1:0] prev_q;

  seg7_t                 s2_seg_s;
  logic [NUM_DIGITS-1:0] s2_sel_s;
  logic                  changed_s;
  logic [3:0]            sel_ones_s;
  logic [2:0]            sel_idx_s;
  logic                  sel_onehot_s;
  seg7_dec_t             dec_s;

  cap_state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] cnt_inc_s;
  logic       capture_s;

  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic                    upd_q, upd_d;
  logic [2:0]              upd_idx_q, upd_idx_d;
  logic                    err_q, err_d;

  // Two-flop synchronizer for the whole bus, then the previous-sample copy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      s2_q    <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= {seg_i, dig_sel_i};
      s2_q    <= sync1_q;
      prev_q  <= s2_q;
    end
  end

  assign s2_seg_s  = s2_q[BUS_W-1 -: 7];
  assign s2_sel_s  = s2_q[NUM_DIGITS-1:0];
  assign changed_s = (s2_q != prev_q);

  // Population count and index of the synchronized digit select.
  always_comb begin
    sel_ones_s = 4'd0;
    sel_idx_s  = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      sel_ones_s = sel_ones_s + {3'b000, s2_sel_s[i]};
      if (s2_sel_s[i]) begin
        sel_idx_s = 3'(i);
      end else begin
        sel_idx_s = sel_idx_s;
      end
    end
    sel_onehot_s = (sel_ones_s == 4'd1);
  end

  seg7_pattern_decode u_decode (
    .pattern_i (s2_seg_s),
    .dec_o     (dec_s)
  );

  assign cnt_inc_s = (cnt_q == 8'hFF) ? 8'hFF : (cnt_q + 8'd1);

  // Stability FSM: counts identical samples and fires capture once per run.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_onehot_s) begin
          state_d = ST_COUNT;
          cnt_d   = 8'd1;
        end else begin
          cnt_d   = 8'd0;
        end
      end
      ST_COUNT: begin
        if (!sel_onehot_s) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else if (changed_s) begin
          cnt_d   = 8'd1;
        end else begin
          cnt_d = cnt_inc_s;
          if (cnt_inc_s >= STABLE_W) begin
            capture_s = 1'b1;
            state_d   = ST_HOLD;
          end else begin
            state_d   = ST_COUNT;
          end
        end
      end
      ST_HOLD: begin
        if (!sel_onehot_s) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else if (changed_s) begin
          state_d = ST_COUNT;
          cnt_d   = 8'd1;
        end else begin
          // Saturating increment keeps the counter from wrapping on a long hold.
          cnt_d   = cnt_inc_s;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // FSM state and stability counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Register-file update: clear first, then the captured digit overrides it.
  always_comb begin
    value_d   = value_q;
    upd_d     = 1'b0;
    err_d     = 1'b0;
    upd_idx_d = upd_idx_q;
    if (clear_i) begin
      valid_d = '0;
    end else begin
      valid_d = valid_q;
    end
    if (capture_s) begin
      upd_d     = 1'b1;
      upd_idx_d = sel_idx_s;
      err_d     = ~dec_s.legal;
    end else begin
      upd_d     = 1'b0;
    end
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (capture_s && (sel_idx_s == 3'(k))) begin
        valid_d[k] = dec_s.legal & ~dec_s.blank;
        if (dec_s.legal && !dec_s.blank) begin
          value_d[4*k +: 4] = dec_s.nibble;
        end else begin
          value_d[4*k +: 4] = value_q[4*k +: 4];
        end
      end else begin
        valid_d[k] = valid_d[k];
      end
    end
  end

  // Registered outputs of the capture path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q   <= '0;
      valid_q   <= '0;
      upd_q     <= 1'b0;
      upd_idx_q <= 3'd0;
      err_q     <= 1'b0;
    end else begin
      value_q   <= value_d;
      valid_q   <= valid_d;
      upd_q     <= upd_d;
      upd_idx_q <= upd_idx_d;
      err_q     <= err_d;
    end
  end

  assign value_o   = value_q;
  assign valid_o   = valid_q;
  assign upd_o     = upd_q;
  assign upd_idx_o = upd_idx_q;
  assign err_o     = err_q;

`ifdef SEGDEC_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating illegal-pattern counter; clear wins over a coincident error.
  always_comb begin
    if (clear_i) begin
      err_cnt_d = 8'd0;
    end else if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Error counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule
